// File: rtl/vga_pkg.sv
// Shared screen geometry, pixel record and plot_buffer FSM states.
package vga_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned FB_AW    = 15;
  localparam int unsigned FB_DEPTH = 19200;

  localparam logic [FB_AW-1:0] FB_LAST = FB_AW'(FB_DEPTH - 1);

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    CLEAR_WAIT
  } state_e;

  // y*160 + x using shifts; the largest on-screen result is 19199, so 15 bits never wrap.
  function automatic logic [FB_AW-1:0] fb_addr_of(input logic [7:0] x, input logic [6:0] y);
    logic [FB_AW-1:0] yw;
    logic [FB_AW-1:0] xw;
    yw = {8'b0, y};
    xw = {7'b0, x};
    return (yw << 7) + (yw << 5) + xw;
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// Synchronous pixel FIFO; pointers carry an extra wrap bit to tell full from empty.
module plot_fifo
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  pixel_t wdata,
  input  logic   pop,
  output pixel_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  pixel_t      mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/plot_buffer.sv
// Clips and buffers drawing-engine pixels, then writes them (or a full-screen clear sweep)
// to the framebuffer through a one-entry valid/ready output register.
module plot_buffer
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_x,
  input  logic [6:0]       in_y,
  input  logic [2:0]       in_colour,
  input  logic             in_plot,
  input  logic             clear_start,
  input  logic [2:0]       clear_colour,
  output logic             clear_done,
  output logic             busy,
  output logic             overflow,
  output logic [FB_AW-1:0] fb_addr,
  output logic [2:0]       fb_data,
  output logic             fb_we,
  input  logic             fb_ready
);

  state_e           state_q, state_d;
  logic [FB_AW-1:0] cnt_q, cnt_d;
  logic [2:0]       clr_colour_q, clr_colour_d;
  logic [FB_AW-1:0] addr_q, addr_d;
  logic [2:0]       data_q, data_d;
  logic             we_q, we_d;
  logic             done_q, done_d;
  logic             overflow_q;

  logic   accept, push, pop, full, empty, out_free;
  pixel_t wr_pix, rd_pix;

  assign accept   = in_plot && (in_x < 8'(SCREEN_W)) && (in_y < 7'(SCREEN_H));
  // A full FIFO still takes a pixel when the same cycle frees a slot.
  assign push     = accept && (!full || pop);
  assign out_free = !we_q || fb_ready;
  assign wr_pix   = '{x: in_x, y: in_y, colour: in_colour};

  plot_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .wdata(wr_pix),
    .pop  (pop),
    .rdata(rd_pix),
    .full (full),
    .empty(empty)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clr_colour_d = clr_colour_q;
    we_d         = we_q && !fb_ready;
    addr_d       = addr_q;
    data_d       = data_q;
    done_d       = 1'b0;
    pop          = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A pending FIFO write stays in the register until accepted; the sweep waits for it.
        if (clear_start) begin
          clr_colour_d = clear_colour;
          cnt_d        = '0;
          state_d      = CLEAR;
        end else if (out_free && !empty) begin
          pop    = 1'b1;
          we_d   = 1'b1;
          addr_d = fb_addr_of(rd_pix.x, rd_pix.y);
          data_d = rd_pix.colour;
        end
      end
      CLEAR: begin
        if (out_free) begin
          we_d   = 1'b1;
          addr_d = cnt_q;
          data_d = clr_colour_q;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == FB_LAST) state_d = CLEAR_WAIT;
        end
      end
      CLEAR_WAIT: begin
        if (we_q && fb_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      clr_colour_q <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      we_q         <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clr_colour_q <= clr_colour_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      we_q         <= we_d;
      done_q       <= done_d;
      if (accept && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign fb_addr    = addr_q;
  assign fb_data    = data_q;
  assign fb_we      = we_q;
  assign clear_done = done_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE) || !empty || we_q;

endmodule

// File: doc/plot_buffer.md
Name: plot_buffer

Overview:
- Sits directly downstream of the shape-drawing engines (circle, reuleaux, fillscreen) and consumes their vga_x/vga_y/vga_colour/vga_plot pixel stream.
- Clips off-screen pixels and buffers accepted pixels in a FIFO.
- Converts each buffered pixel to a linear framebuffer address and writes it to a 160x120 3-bit framebuffer through a valid/ready write port.
- Also provides a hardware screen-clear sweep, so drawing engines never stall on memory.

Parameters:
- DEPTH, 16: FIFO entries; power of two, minimum 4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_x  in  8  pixel x from drawing engine
- in_y  in  7  pixel y from drawing engine
- in_colour  in  3  pixel colour
- in_plot  in  1  pixel valid, one pixel per cycle; no backpressure
- clear_start  in  1  request full-screen clear
- clear_colour  in  3  colour used for the clear, sampled on accepted clear_start
- clear_done  out  1  one-cycle pulse after the last clear write is accepted
- busy  out  1  high while clearing or while the FIFO or output register holds data
- overflow  out  1  sticky; set when an on-screen pixel is dropped because the FIFO is full
- fb_addr  out  15  framebuffer address, y*160+x
- fb_data  out  3  framebuffer write colour
- fb_we  out  1  write valid
- fb_ready  in  1  framebuffer accepts the write on a cycle where fb_we && fb_ready

Behaviour:
- Reset: asynchronous, active-low; applies immediately, mid-clear or mid-drain included.
  - FIFO emptied; FSM forced to IDLE.
  - fb_we=0, fb_addr=0, fb_data=0, clear_done=0, busy=0, overflow=0.
- Clip: in_plot is accepted only if in_x<160 and in_y<120.
  - Clipped pixels are silently discarded and never set overflow.
- Push: accepted pixel is written to the FIFO at the rising edge where in_plot=1.
  - FIFO full with no pop in the same cycle: pixel dropped, overflow set.
  - Full with a simultaneous pop: push succeeds.
- Output register (fb_addr/fb_data/fb_we) is a one-entry skid.
  - Loads when empty, or when its current write is accepted (fb_we && fb_ready) in the same cycle.
  - fb_we, fb_addr and fb_data hold stable while fb_we=1 and fb_ready=0.
- Latency: pixel pushed at edge N appears with fb_we=1 after edge N+1 (FIFO empty, register empty).
  - Sustained throughput is 1 pixel/cycle with fb_ready=1.
- Address: y*160+x = (y<<7)+(y<<5)+x, computed in 15 bits. Maximum 19199; no wrap.
- FSM states:
  - IDLE: drain FIFO into the output register.
    - On clear_start, latch clear_colour, set the sweep counter to 0, go to CLEAR.
  - CLEAR: the output register is fed from the sweep counter (addr=counter, data=latched colour), not the FIFO.
    - The counter increments on each load.
    - Incoming pixels still push into the FIFO.
    - After the load of address 19199, go to CLEAR_WAIT.
  - CLEAR_WAIT: wait until the final write is accepted, then pulse clear_done for 1 cycle and go to IDLE.
    - The FIFO drain resumes afterwards, so pixels drawn during the clear land on top of it.
- clear_start asserted in CLEAR or CLEAR_WAIT: ignored.
- clear_start when the output register holds a pending FIFO pixel: that pixel completes first, then the sweep begins.
- busy = (state!=IDLE) || FIFO non-empty || fb_we.

Decomposition:
- Package vga_pkg:
  - SCREEN_W=160, SCREEN_H=120, FB_AW=15, FB_DEPTH=19200.
  - pixel_t struct {x[7:0], y[6:0], colour[2:0]}.
  - State enum {IDLE, CLEAR, CLEAR_WAIT}.
- Sub-module plot_fifo: synchronous FIFO of pixel_t, parameter DEPTH, with push/pop/full/empty.
  - Uses wrap-around pointers with an extra MSB for the full/empty distinction.

Test Plan:
- Single pixel: in_plot x=80,y=60,colour=3'b010, fb_ready=1 -> one fb_we pulse two edges later with fb_addr=9680, fb_data=3'b010; busy returns low.
- Clipping: pixels (160,10), (10,120) and (255,127), then (159,119) -> only one write, fb_addr=19199; overflow stays 0.
- Backpressure/overflow, DEPTH=16:
  - Hold fb_ready=0 and push 20 on-screen pixels -> register holds the first, FIFO holds 16, 3 dropped, overflow=1.
  - Release fb_ready -> exactly 17 writes in push order with stable addr/data during stalls.
- Clear: clear_start with clear_colour=3'b000, fb_ready=1 -> 19200 consecutive writes with addresses 0..19199, then a single clear_done pulse.
  - A second clear_start mid-sweep has no effect.
- Pixels during clear: push x=50,y=50 mid-sweep -> write to address 8050 occurs after the clear_done pulse, not before.
- Reset mid-operation: assert rst_n=0 asynchronously mid-clear with FIFO non-empty -> outputs zero immediately, no further writes after release, busy=0, overflow=0.
